// File: rtl/spi_master_core.sv
// Byte-oriented SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with per-byte chip-select framing.
// spi_clk runs at f(clk)/(2*DIV); every registered pad output changes only on a half-period tick or on acceptance.
module spi_master_core #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       spi_clk,
    input  logic [7:0] user_in,
    input  logic       user_in_last,
    input  logic       user_in_stb,
    output logic       user_in_ready,
    output logic [7:0] user_out,
    output logic       user_out_stb,
    output logic       busy
);

    // state | meaning
    // IDLE  | CS released, waiting for a byte
    // SETUP | CS low, MOSI holds bit7, one tick before the first rise
    // SHIFT | remaining rise/fall ticks of the byte
    // WAIT  | CS still low, waiting for the next byte of the frame
    // HOLD  | one tick of CS low after the last fall
    // CSH   | one tick of CS high before returning to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_WAIT,
        S_HOLD,
        S_CSH
    } state_t;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          tick;

    logic [7:0] tx_q,    tx_nxt;
    logic [7:0] rx_q,    rx_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic       last_q,  last_nxt;
    logic       sclk_q,  sclk_nxt;
    logic       mosi_q,  mosi_nxt;
    logic       cs_n_q,  cs_nxt;
    logic [7:0] uo_q,    uo_nxt;
    logic       stb_q,   stb_nxt;

    assign tick = (cnt == '0);

    // Half-period timer: restarts on every state change and on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (tick || (state_nxt != state)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            bit_cnt <= 3'd0;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            uo_q    <= 8'h00;
            stb_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_q    <= tx_nxt;
            rx_q    <= rx_nxt;
            bit_cnt <= bit_nxt;
            last_q  <= last_nxt;
            sclk_q  <= sclk_nxt;
            mosi_q  <= mosi_nxt;
            cs_n_q  <= cs_nxt;
            uo_q    <= uo_nxt;
            stb_q   <= stb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (user_in_stb) state_nxt = S_SETUP;
            S_SETUP: if (tick) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (tick && sclk_q && (bit_cnt == 3'd7)) begin
                    state_nxt = last_q ? S_HOLD : S_WAIT;
                end
            end
            S_WAIT:  if (user_in_stb) state_nxt = S_SETUP;
            S_HOLD:  if (tick) state_nxt = S_CSH;
            S_CSH:   if (tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The SETUP expiry edge is also the first rising edge of spi_clk.
    always_comb begin
        tx_nxt   = tx_q;
        rx_nxt   = rx_q;
        bit_nxt  = bit_cnt;
        last_nxt = last_q;
        sclk_nxt = sclk_q;
        mosi_nxt = mosi_q;
        cs_nxt   = cs_n_q;
        uo_nxt   = uo_q;
        stb_nxt  = 1'b0;
        case (state)
            S_IDLE, S_WAIT: begin
                if (user_in_stb) begin
                    tx_nxt   = user_in;
                    last_nxt = user_in_last;
                    bit_nxt  = 3'd0;
                    cs_nxt   = 1'b0;
                    mosi_nxt = user_in[7];
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_nxt = 1'b1;
                    rx_nxt   = {rx_q[6:0], spi_miso};
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_nxt = 1'b0;
                        bit_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            uo_nxt   = rx_q;
                            stb_nxt  = 1'b1;
                            mosi_nxt = 1'b0;
                        end else begin
                            mosi_nxt = tx_q[6];
                            tx_nxt   = {tx_q[6:0], 1'b0};
                        end
                    end else begin
                        sclk_nxt = 1'b1;
                        rx_nxt   = {rx_q[6:0], spi_miso};
                    end
                end
            end
            S_HOLD: begin
                if (tick) cs_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    assign spi_clk       = sclk_q;
    assign spi_mosi      = mosi_q;
    assign spi_cs_n      = cs_n_q;
    assign user_out      = uo_q;
    assign user_out_stb  = stb_q;
    assign user_in_ready = (state == S_IDLE) || (state == S_WAIT);
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core: DIV=2 instance for the main scenarios, DIV=1 instance for the fast build.
module tb_spi_master_core;

    localparam int DIV1 = 2;
    localparam int DIV2 = 1;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DIV=2 instance
    logic       spi_mosi, spi_miso, spi_cs_n, spi_clk;
    logic [7:0] user_in, user_out;
    logic       user_in_last, user_in_stb, user_in_ready, user_out_stb, busy;

    // DIV=1 instance
    logic       b_mosi, b_cs_n, b_sclk;
    logic [7:0] b_in, b_out;
    logic       b_last, b_stb, b_ready, b_out_stb, b_busy;

    spi_master_core #(.DIV(DIV1)) dut (
        .clk(clk), .rst(rst),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
        .user_in(user_in), .user_in_last(user_in_last), .user_in_stb(user_in_stb),
        .user_in_ready(user_in_ready), .user_out(user_out), .user_out_stb(user_out_stb),
        .busy(busy)
    );

    spi_master_core #(.DIV(DIV2)) dut_fast (
        .clk(clk), .rst(rst),
        .spi_mosi(b_mosi), .spi_miso(b_mosi), .spi_cs_n(b_cs_n), .spi_clk(b_sclk),
        .user_in(b_in), .user_in_last(b_last), .user_in_stb(b_stb),
        .user_in_ready(b_ready), .user_out(b_out), .user_out_stb(b_out_stb),
        .busy(b_busy)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   rise_cyc[$];
    int   b_rise_cyc[$];
    int   rises = 0, b_rises = 0, strobes = 0;
    int   cs_falls = 0, cs_rises = 0;
    int   violations = 0;
    logic [31:0] mosi_log = '0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, b_prev_sclk = 1'b0;

    // Slave model: mode 0, MSB first, advances on each falling spi_clk.
    logic        loopback = 1'b1;
    logic [23:0] slave_bits = 24'hC1C2C3;
    int          slave_ptr = 23;
    logic        slave_miso;

    always_comb begin
        slave_miso = 1'b0;
        if (slave_ptr >= 0) slave_miso = slave_bits[slave_ptr[4:0]];
    end
    assign spi_miso = loopback ? spi_mosi : slave_miso;

    always @(negedge spi_clk) if (slave_ptr >= 0) slave_ptr = slave_ptr - 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge spi_clk) begin
        rises = rises + 1;
        mosi_log = {mosi_log[30:0], spi_mosi};
    end
    always @(posedge b_sclk) b_rises = b_rises + 1;
    always @(negedge spi_cs_n) cs_falls = cs_falls + 1;
    always @(posedge spi_cs_n) cs_rises = cs_rises + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops on each strobe, plus continuous pad-protocol watch.
    always @(negedge clk) begin
        exp_t e;
        if (user_out_stb === 1'b1) begin
            strobes = strobes + 1;
            if (q1.size() == 0) begin
                chk("unexpected_strobe", {24'h0, user_out}, 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                chk("rx_byte", {24'h0, user_out}, {24'h0, e.d});
                chk("rx_strobe_cycle", cyc, e.c);
            end
        end
        if (b_out_stb === 1'b1) begin
            if (q2.size() == 0) begin
                chk("fast_unexpected_strobe", {24'h0, b_out}, 32'hFFFF_FFFF);
            end else begin
                e = q2.pop_front();
                chk("fast_rx_byte", {24'h0, b_out}, {24'h0, e.d});
                chk("fast_rx_strobe_cycle", cyc, e.c);
            end
        end
        if (spi_clk && !prev_sclk) begin
            rise_cyc.push_back(cyc);
            if (spi_mosi !== prev_mosi) violations = violations + 1;
        end
        if (spi_clk && spi_cs_n) violations = violations + 1;
        if (b_sclk && !b_prev_sclk) b_rise_cyc.push_back(cyc);
        prev_sclk   = spi_clk;
        prev_mosi   = spi_mosi;
        b_prev_sclk = b_sclk;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || b_busy || q1.size() != 0 || q2.size() != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL wait_idle: timeout, busy=%0b q1=%0d q2=%0d", busy, q1.size(), q2.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b, input logic lst, input bit hold,
                        input bit expect_rx, input logic [7:0] rxv, output int t_acc);
        int k = 0;
        user_in      = b;
        user_in_last = lst;
        user_in_stb  = 1'b1;
        while (!user_in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!user_in_ready) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL send_ready: timeout for byte %0h", b);
        end
        t_acc = cyc;
        if (expect_rx) q1.push_back('{d: rxv, c: cyc + 1 + 16 * DIV1});
        @(negedge clk);
        if (!hold) user_in_stb = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ta, tb, tc, r0, s0, f0, c0, k;
        logic bad;
        rst = 1'b1;
        user_in = 8'h00; user_in_last = 1'b0; user_in_stb = 1'b0;
        b_in = 8'h00; b_last = 1'b0; b_stb = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_user_out", user_out, 0);
        chk("rst_stb", user_out_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", user_in_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte loopback
        rise_cyc.delete();
        r0 = rises;
        send(8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, t);
        chk("t1_cs_low_t0p1", spi_cs_n, 0);
        chk("t1_mosi_bit7", spi_mosi, 1);
        wait_cyc(t + 34);
        chk("t1_cs_still_low", spi_cs_n, 0);
        wait_cyc(t + 35);
        chk("t1_cs_high_t0p35", spi_cs_n, 1);
        wait_cyc(t + 36);
        chk("t1_not_ready_t0p36", user_in_ready, 0);
        wait_cyc(t + 37);
        chk("t1_ready_t0p37", user_in_ready, 1);
        wait_idle();
        chk("t1_rises", rises - r0, 8);
        chk("t1_first_rise", rise_cyc.size() > 0 ? rise_cyc[0] : -1, t + 3);
        chk("t1_last_rise", rise_cyc.size() > 7 ? rise_cyc[7] : -1, t + 31);

        // Multi-byte frame with slave model
        loopback = 1'b0;
        slave_ptr = 23;
        rise_cyc.delete();
        r0 = rises; f0 = cs_falls; c0 = cs_rises;
        send(8'h01, 1'b0, 1'b1, 1'b1, 8'hC1, ta);
        send(8'h02, 1'b0, 1'b1, 1'b1, 8'hC2, tb);
        send(8'h03, 1'b1, 1'b0, 1'b1, 8'hC3, tc);
        wait_idle();
        chk("t2_rises", rises - r0, 24);
        chk("t2_cs_falls", cs_falls - f0, 1);
        chk("t2_cs_rises", cs_rises - c0, 1);
        chk("t2_mosi_bits", mosi_log[23:0], 24'h010203);
        chk("t2_wait_accept_b2", tb, ta + 1 + 16 * DIV1);
        chk("t2_wait_accept_b3", tc, tb + 1 + 16 * DIV1);
        chk("t2_b2_first_rise", rise_cyc.size() > 8 ? rise_cyc[8] : -1,
            ta + 1 + 16 * DIV1 + DIV1 + 1);
        loopback = 1'b1;

        // WAIT stall
        r0 = rises; s0 = strobes;
        send(8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, t);
        wait_cyc(t + 1 + 16 * DIV1);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (spi_cs_n !== 1'b0 || spi_clk !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("t3_gap_cs_low_clk_low", bad, 0);
        chk("t3_ready_in_wait", user_in_ready, 1);
        send(8'h99, 1'b1, 1'b0, 1'b1, 8'h99, t);
        wait_idle();
        chk("t3_strobes", strobes - s0, 2);
        chk("t3_rises", rises - r0, 16);
        chk("t3_mosi_bits", mosi_log[15:0], 16'h3C99);

        // Strobe while busy
        r0 = rises; s0 = strobes;
        send(8'h66, 1'b1, 1'b0, 1'b1, 8'h66, t);
        wait_cyc(t + 10);
        user_in = 8'hFF; user_in_last = 1'b0; user_in_stb = 1'b1;
        @(negedge clk);
        user_in_stb = 1'b0;
        wait_idle();
        chk("t4_rises", rises - r0, 8);
        chk("t4_strobes", strobes - s0, 1);
        chk("t4_mosi_bits", mosi_log[7:0], 8'h66);

        // Reset mid-byte
        r0 = rises; s0 = strobes;
        send(8'h33, 1'b1, 1'b0, 1'b0, 8'h00, t);
        k = 0;
        while ((rises - r0) < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_third_rise", rises - r0, 3);
        rst = 1'b1;
        #1;
        chk("t5_cs_n", spi_cs_n, 1);
        chk("t5_sclk", spi_clk, 0);
        chk("t5_mosi", spi_mosi, 0);
        chk("t5_busy", busy, 0);
        chk("t5_user_out", user_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_no_strobe", strobes - s0, 0);
        r0 = rises;
        send(8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, t);
        wait_idle();
        chk("t5_rises_after", rises - r0, 8);
        chk("t5_mosi_bits", mosi_log[7:0], 8'h5A);

        // DIV=1 instance loopback
        b_rise_cyc.delete();
        r0 = b_rises;
        b_in = 8'h81; b_last = 1'b1; b_stb = 1'b1;
        k = 0;
        while (!b_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        t = cyc;
        q2.push_back('{d: 8'h81, c: t + 17});
        @(negedge clk);
        b_stb = 1'b0;
        wait_idle();
        chk("t6_rises", b_rises - r0, 8);
        chk("t6_first_rise", b_rise_cyc.size() > 0 ? b_rise_cyc[0] : -1, t + 2);
        bad = (b_rise_cyc.size() != 8);
        for (int i = 1; i < b_rise_cyc.size(); i++) begin
            if (b_rise_cyc[i] - b_rise_cyc[i-1] != 2) bad = 1'b1;
        end
        chk("t6_sclk_period_2", bad, 0);

        chk("protocol_violations", violations, 0);
        chk("scoreboard_empty", q1.size() + q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
